// File: rtl/reg_file.sv
// ============================================================================
// reg_file : two-read/one-write register file with NZP condition codes and
//            per-register busy (pending-writer) flags.
//            Optional macro REG_FILE_BYPASS_EN: same-cycle write-to-read forward.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reg_file #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             cc_update,
  input  logic [AW-1:0]    rd0_addr,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic [WIDTH-1:0] rd1_data,
  output logic [2:0]       cc_nzp,
  input  logic             lock_en,
  input  logic [AW-1:0]    lock_addr,
  output logic [DEPTH-1:0] busy
);

  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_regs [DEPTH];
  logic [2:0]       r_cc;
  logic [DEPTH-1:0] r_busy;
  logic [DEPTH-1:0] w_busy_next;
  logic             w_wr_ok;
  logic             w_lock_ok;
  logic [AW-1:0]    w_rd_addr [2];
  logic [WIDTH-1:0] w_rd_data [2];

  // Out-of-range indices only exist when DEPTH is not a power of two.
  assign w_wr_ok   = wr_en   && ({1'b0, wr_addr}   < C_DEPTH);
  assign w_lock_ok = lock_en && ({1'b0, lock_addr} < C_DEPTH);

  function automatic logic [2:0] classify(input logic [WIDTH-1:0] d);
    if (d[WIDTH-1])   return 3'b100;
    else if (d == '0) return 3'b010;
    else              return 3'b001;
  endfunction

  // Lock is applied after the write clear so a same-index collision stays busy.
  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_wr_ok && (wr_addr == AW'(i)))     w_busy_next[i] = 1'b0;
      if (w_lock_ok && (lock_addr == AW'(i))) w_busy_next[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      r_cc   <= 3'b010;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && (wr_addr == AW'(i))) r_regs[i] <= wr_data;
      end
      if (w_wr_ok && cc_update) r_cc <= classify(wr_data);
      r_busy <= w_busy_next;
    end
  end

  assign w_rd_addr[0] = rd0_addr;
  assign w_rd_addr[1] = rd1_addr;

  generate
    for (genvar p = 0; p < 2; p++) begin : g_rd_port
      always_comb begin
        w_rd_data[p] = '0;
        for (int i = 0; i < DEPTH; i++) begin
          if (w_rd_addr[p] == AW'(i)) w_rd_data[p] = r_regs[i];
        end
`ifdef REG_FILE_BYPASS_EN
        if (w_wr_ok && (w_rd_addr[p] == wr_addr)) w_rd_data[p] = wr_data;
`endif
        // Forwarded data must not leak out while reset is held.
        if (!rst_n) w_rd_data[p] = '0;
      end
    end
  endgenerate

  assign rd0_data = w_rd_data[0];
  assign rd1_data = w_rd_data[1];
  assign cc_nzp   = r_cc;
  assign busy     = r_busy;

endmodule

`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 8, number of registers (2..256); AW = $clog2(DEPTH) derived, not overridable.
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port wr_en  input  1  write strobe.
REQ-006 The block SHALL have port wr_addr  input  AW  write register index.
REQ-007 The block SHALL have port wr_data  input  WIDTH  write data.
REQ-008 The block SHALL have port cc_update  input  1  qualifies wr_en to also update condition codes.
REQ-009 The block SHALL have port rd0_addr / rd1_addr  input  AW each  read indices.
REQ-010 The block SHALL have port rd0_data / rd1_data  output  WIDTH each  read data.
REQ-011 The block SHALL have port cc_nzp  output  3  condition codes {N,Z,P}.
REQ-012 The block SHALL have port lock_en  input  1  mark a register busy (pending writer issued).
REQ-013 The block SHALL have port lock_addr  input  AW  register to mark busy.
REQ-014 The block SHALL have port busy  output  DEPTH  per-register pending-write flags.

Function
REQ-015 Write: on rising clk with wr_en=1 and wr_addr<DEPTH, regs[wr_addr] SHALL take wr_data; latency 1 cycle.
REQ-016 Writes with wr_addr>=DEPTH (non-power-of-2 DEPTH) SHALL be ignored: no register, cc_nzp or busy change.
REQ-017 Reads SHALL be combinational: rdN_data = regs[rdN_addr]; rdN_addr>=DEPTH SHALL return all zeros.
REQ-018 Both read ports SHALL be independent; equal addresses return identical data.
REQ-019 CC: on rising clk with wr_en=1, cc_update=1 and valid wr_addr, cc_nzp SHALL become 100 if wr_data[WIDTH-1]=1, 010 if wr_data==0, else 001.
REQ-020 cc_nzp SHALL be exactly one-hot at all times after reset.
REQ-021 cc_update with wr_en=0 SHALL have no effect.
REQ-022 Busy: lock_en=1 SHALL set busy[lock_addr] on rising clk; valid wr_en SHALL clear busy[wr_addr] on rising clk.
REQ-023 Simultaneous lock_en and wr_en on the same address SHALL leave busy set (set wins); on different addresses both take effect.
REQ-024 lock_addr>=DEPTH SHALL be ignored.
REQ-025 busy SHALL not gate writes: a write to a non-busy register is accepted and leaves busy clear.

Reset
REQ-026 rst_n=0 SHALL immediately, asynchronously, clear all registers to 0, busy to 0, and set cc_nzp to 010.
REQ-027 Reset asserted mid-write SHALL discard the write; state holds reset values until the first rising clk after rst_n deasserts.
REQ-028 rd0_data/rd1_data SHALL read 0 for every address during reset.

Configuration
REQ-029 Macro REG_FILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With REG_FILE_BYPASS_EN defined, when wr_en=1, wr_addr valid and rdN_addr==wr_addr, rdN_data SHALL equal wr_data in the same cycle (combinational bypass, both ports).
REQ-031 Without REG_FILE_BYPASS_EN, rdN_data SHALL return the pre-write register value until after the rising edge.
REQ-032 The macro SHALL not affect cc_nzp, busy or reset behaviour.

Verification
REQ-033 Reset then read all addresses on both ports -> all 0, cc_nzp=010, busy=0.
REQ-034 Write R3=16'h8001 with cc_update=1, next cycle read rd0=3 -> 16'h8001, cc_nzp=100; write R3=0 with cc_update=0 -> cc_nzp stays 100.
REQ-035 Write R5=16'h1234 with rd1_addr=5 in the same cycle -> rd1_data=16'h1234 pre-edge with REG_FILE_BYPASS_EN, old value 0 without; 16'h1234 post-edge in both builds.
REQ-036 lock R2 -> busy=8'h04; same cycle lock R2 and write R2 -> busy stays 8'h04; write R2 alone -> busy=8'h00.
REQ-037 DEPTH=6: write wr_addr=7 data 16'hFFFF with cc_update=1 -> no register change, cc_nzp unchanged; read rd0_addr=7 -> 0.
REQ-038 Assert rst_n low between clock edges after writing R1=16'h0042 -> rd0_data(R1)=0 and cc_nzp=010 before the next clk edge.
